// File: rtl/comparator_multicycle.sv
// Multi-cycle magnitude/equality comparator: scans CHUNK-bit slices from the
// top down, one per cycle, and stops at the first differing slice.
module comparator_multicycle #(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         equals,
    output logic         less_than
);

    localparam int unsigned NC = (CHUNK == 0) ? 1 : N / CHUNK;
    localparam int unsigned KW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [KW-1:0]    K_TOP    = KW'(NC - 1);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    generate
        if (CHUNK == 0 || CHUNK > N || NC * CHUNK != N) begin : g_bad_params
            $error("comparator_multicycle: N must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             ov_d, eq_d, lt_d;
    logic [CHUNK-1:0] sa, sb, sa_adj, sb_adj;
    logic             top_signed, slice_ne, slice_lt;

    assign in_ready = (state_q == IDLE) && !rst;

    // Select slice k; the top slice of a signed compare has its sign bit
    // flipped so an unsigned compare yields the two's-complement ordering.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < NC; i++) begin
            if (k_q == KW'(i)) begin
                sa = a_q[i*CHUNK +: CHUNK];
                sb = b_q[i*CHUNK +: CHUNK];
            end
        end
        top_signed = sgn_q && (k_q == K_TOP);
        sa_adj     = sa ^ (top_signed ? MSB_MASK : '0);
        sb_adj     = sb ^ (top_signed ? MSB_MASK : '0);
        slice_ne   = (sa != sb);
        slice_lt   = (sa_adj < sb_adj);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        ov_d    = out_valid;
        eq_d    = equals;
        lt_d    = less_than;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    k_d     = K_TOP;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (slice_ne) begin
                    eq_d    = 1'b0;
                    lt_d    = slice_lt;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else if (k_q == KW'(0)) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= K_TOP;
            out_valid <= 1'b0;
            equals    <= 1'b0;
            less_than <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            out_valid <= ov_d;
            equals    <= eq_d;
            less_than <= lt_d;
        end
    end

    // Operands only change on the accept cycle, so they need no reset.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sgn_q <= sgn_d;
    end

endmodule
